m_stage_lsu: RTL and testbench

//  Parametrised memory stage: registers the X-stage result and control, runs the

---
 rtl/m_stage_lsu_if.sv | 41 ++++
 rtl/m_stage_lsu.sv | 193 +++++++++++++++++++
 tb/tb_m_stage_lsu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/m_stage_lsu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : m_stage_lsu_if
//  Purpose  : Data-memory request/response bus between the M-stage LSU and
//             the data memory.
//  Ports    : mem_req_vld/rdy   request handshake
//             mem_req_we        1 store, 0 load
//             mem_req_addr      address aligned down to the bus width
//             mem_req_be        byte enables
//             mem_req_wdata     store data replicated across byte lanes
//             mem_rsp_vld/data  load response
//  Modports : master (LSU side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface m_stage_lsu_if #(
    parameter int N_BITS    = 32,
    parameter int ADDR_BITS = 32
);
    localparam int BE_W = N_BITS / 8;

    logic                 mem_req_vld;
    logic                 mem_req_rdy;
    logic                 mem_req_we;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [BE_W-1:0]      mem_req_be;
    logic [N_BITS-1:0]    mem_req_wdata;
    logic                 mem_rsp_vld;
    logic [N_BITS-1:0]    mem_rsp_data;

    modport master (
        output mem_req_vld, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_data
    );

    modport slave (
        input  mem_req_vld, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/m_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : m_stage_lsu
//  Purpose  : Memory pipeline stage. Registers the X-stage result/control,
//             runs the data-memory handshake and emits one writeback packet
//             per instruction to W. Handles byte enables, load extract and
//             extend, misalignment detection and back-pressure to X.
//  Ports    : clk, rst_n (async, active low)
//             x_vld / m_rdy           X->M handshake
//             exe_data_in..rd_wen_in  X-stage result and control
//             mem                     data-memory bus (master modport)
//             wb_vld, wb_wen, wb_rd_addr, data_out, misalign_err  to W
//  Revision : 1.0 - initial release
// ============================================================================
module m_stage_lsu #(
    parameter int N_BITS    = 32,
    parameter int ADDR_BITS = 32,
    parameter int RF_ADDR_W = 5
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 x_vld,
    output logic                      m_rdy,
    input  wire logic [N_BITS-1:0]    exe_data_in,
    input  wire logic [N_BITS-1:0]    st_data_in,
    input  wire logic [1:0]           mem_op_in,
    input  wire logic [1:0]           mem_size_in,
    input  wire logic                 mem_uns_in,
    input  wire logic [RF_ADDR_W-1:0] rd_addr_in,
    input  wire logic                 rd_wen_in,
    m_stage_lsu_if.master             mem,
    output logic                      wb_vld,
    output logic                      wb_wen,
    output logic [RF_ADDR_W-1:0]      wb_rd_addr,
    output logic [N_BITS-1:0]         data_out,
    output logic                      misalign_err
);
    localparam int BE_W  = N_BITS / 8;
    localparam int OFF_W = $clog2(BE_W);

    localparam logic [1:0] c_OP_LOAD  = 2'd1;
    localparam logic [1:0] c_OP_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_vld;
    logic                  r_is_mem;
    logic                  r_is_st;
    logic                  r_mis;
    logic [N_BITS-1:0]     r_exe;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [OFF_W-1:0]      r_off;
    logic [RF_ADDR_W-1:0]  r_rd;
    logic                  r_wen;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [BE_W-1:0]       r_be;
    logic [N_BITS-1:0]     r_wdata;

    // Capture-time decode of the incoming instruction
    logic [OFF_W-1:0]  w_off;
    logic              w_is_mem;
    logic              w_mis;
    logic [BE_W-1:0]   w_be;
    logic [N_BITS-1:0] w_wdata;

    assign w_off    = exe_data_in[OFF_W-1:0];
    assign w_is_mem = (mem_op_in == c_OP_LOAD) || (mem_op_in == c_OP_STORE);

    always_comb begin
        w_mis   = 1'b0;
        w_be    = '1;
        w_wdata = st_data_in;
        case (mem_size_in)
            2'd0: begin
                w_be    = BE_W'(1) << w_off;
                w_wdata = {BE_W{st_data_in[7:0]}};
            end
            2'd1: begin
                w_mis   = w_off[0];
                w_be    = BE_W'(3) << w_off;
                w_wdata = {(BE_W/2){st_data_in[15:0]}};
            end
            2'd2: begin
                w_mis   = (w_off[1:0] != 2'd0);
                w_be    = BE_W'(15) << w_off;
                w_wdata = {(BE_W/4){st_data_in[31:0]}};
            end
            default: begin
                // Doubleword exists only on a 64-bit datapath
                w_mis   = (N_BITS == 32) || (w_off != '0);
                w_be    = '1;
                w_wdata = st_data_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_vld    <= 1'b0;
            r_is_mem <= 1'b0;
            r_is_st  <= 1'b0;
            r_mis    <= 1'b0;
            r_exe    <= '0;
            r_size   <= 2'd0;
            r_uns    <= 1'b0;
            r_off    <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else if (m_rdy) begin
            r_vld <= x_vld;
            if (x_vld) begin
                r_is_mem <= w_is_mem;
                r_is_st  <= (mem_op_in == c_OP_STORE);
                r_mis    <= w_is_mem && w_mis;
                r_exe    <= exe_data_in;
                r_size   <= mem_size_in;
                r_uns    <= mem_uns_in;
                r_off    <= w_off;
                r_rd     <= rd_addr_in;
                r_wen    <= rd_wen_in;
                r_addr   <= {exe_data_in[ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_state  <= (w_is_mem && !w_mis) ? ST_REQ : ST_IDLE;
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (r_state == ST_REQ && mem.mem_req_rdy) begin
            r_state <= r_is_st ? ST_IDLE : ST_RSP;
        end
    end

    // Load extract: shift the addressed lane down, then extend by size
    logic [N_BITS-1:0] w_shift;
    logic [N_BITS-1:0] w_ld_data;

    assign w_shift = mem.mem_rsp_data >> {r_off, 3'b000};

    always_comb begin
        w_ld_data = w_shift;
        case (r_size)
            2'd0:    w_ld_data = r_uns ? N_BITS'(w_shift[7:0])
                                       : N_BITS'($signed(w_shift[7:0]));
            2'd1:    w_ld_data = r_uns ? N_BITS'(w_shift[15:0])
                                       : N_BITS'($signed(w_shift[15:0]));
            2'd2:    w_ld_data = r_uns ? N_BITS'(w_shift[31:0])
                                       : N_BITS'($signed(w_shift[31:0]));
            default: w_ld_data = w_shift;
        endcase
    end

    logic w_in_req;
    logic w_wb_alu;
    logic w_wb_mis;
    logic w_wb_st;
    logic w_wb_ld;

    assign w_in_req = (r_state == ST_REQ);

    // In IDLE a still-set r_vld on a completed store must not re-fire, so
    // IDLE writebacks come only from non-memory or misaligned captures.
    assign w_wb_alu = (r_state == ST_IDLE) && r_vld && !r_is_mem;
    assign w_wb_mis = (r_state == ST_IDLE) && r_vld && r_is_mem && r_mis;
    assign w_wb_st  = w_in_req && r_is_st && mem.mem_req_rdy;
    assign w_wb_ld  = (r_state == ST_RSP) && mem.mem_rsp_vld;

    assign m_rdy = (r_state == ST_IDLE) || w_wb_ld;

    assign mem.mem_req_vld   = w_in_req;
    assign mem.mem_req_we    = w_in_req && r_is_st;
    assign mem.mem_req_addr  = w_in_req ? r_addr  : '0;
    assign mem.mem_req_be    = w_in_req ? r_be    : '0;
    assign mem.mem_req_wdata = w_in_req ? r_wdata : '0;

    assign wb_vld       = w_wb_alu || w_wb_mis || w_wb_st || w_wb_ld;
    assign wb_wen       = (w_wb_alu || w_wb_ld) && r_wen;
    assign wb_rd_addr   = wb_vld ? r_rd : '0;
    assign data_out     = w_wb_alu ? r_exe : (w_wb_ld ? w_ld_data : '0);
    assign misalign_err = w_wb_mis;

endmodule
`default_nettype wire

// File: tb/tb_m_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_m_stage_lsu
//  Purpose  : Self-checking bench for m_stage_lsu (32-bit configuration).
//             Expected writeback packets are queued when an instruction is
//             driven and compared when the DUT raises wb_vld.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m_stage_lsu;
    localparam int N_BITS = 32;

    logic        clk;
    logic        rst_n;
    logic        x_vld;
    logic        m_rdy;
    logic [31:0] exe_data_in;
    logic [31:0] st_data_in;
    logic [1:0]  mem_op_in;
    logic [1:0]  mem_size_in;
    logic        mem_uns_in;
    logic [4:0]  rd_addr_in;
    logic        rd_wen_in;
    logic        wb_vld;
    logic        wb_wen;
    logic [4:0]  wb_rd_addr;
    logic [31:0] data_out;
    logic        misalign_err;

    m_stage_lsu_if #(.N_BITS(32), .ADDR_BITS(32)) mem_bus ();

    m_stage_lsu #(.N_BITS(32), .ADDR_BITS(32), .RF_ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_vld        (x_vld),
        .m_rdy        (m_rdy),
        .exe_data_in  (exe_data_in),
        .st_data_in   (st_data_in),
        .mem_op_in    (mem_op_in),
        .mem_size_in  (mem_size_in),
        .mem_uns_in   (mem_uns_in),
        .rd_addr_in   (rd_addr_in),
        .rd_wen_in    (rd_wen_in),
        .mem          (mem_bus),
        .wb_vld       (wb_vld),
        .wb_wen       (wb_wen),
        .wb_rd_addr   (wb_rd_addr),
        .data_out     (data_out),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every writeback must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && wb_vld) begin
            if (sb.size() == 0) begin
                check_value("wb_unexpected", 64'(wb_vld), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_value("wb_wen", 64'(wb_wen), 64'(e.wen));
                check_value("wb_rd", 64'(wb_rd_addr), 64'(e.rd));
                check_value("wb_mis", 64'(misalign_err), 64'(e.mis));
                if (e.chk_data)
                    check_value("wb_data", 64'(data_out), 64'(e.data));
            end
        end
    end

    task automatic push_exp(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                            input logic mis, input logic chk);
        exp_t e;
        e.wen = wen; e.rd = rd; e.data = data; e.mis = mis; e.chk_data = chk;
        sb.push_back(e);
    endtask

    // Present one instruction for one clock edge (inputs change at posedge+1)
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] exe, input logic [31:0] st,
                         input logic [4:0] rd, input logic wen);
        x_vld = 1'b1; mem_op_in = op; mem_size_in = size; mem_uns_in = uns;
        exe_data_in = exe; st_data_in = st; rd_addr_in = rd; rd_wen_in = wen;
        @(posedge clk); #1;
        x_vld = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be);
        check_value({tag, "_req_vld"}, 64'(mem_bus.mem_req_vld), 64'd1);
        check_value({tag, "_req_we"}, 64'(mem_bus.mem_req_we), 64'(we));
        check_value({tag, "_req_addr"}, 64'(mem_bus.mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
        check_value({tag, "_req_be"}, 64'(mem_bus.mem_req_be), 64'(be));
        check_value({tag, "_m_rdy"}, 64'(m_rdy), 64'd0);
    endtask

    // Load: `stall` cycles with mem_req_rdy low (bogus response offered meanwhile,
    // which must be ignored), one empty RSP cycle, then the real response.
    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rsp, input int stall,
                           input logic [3:0] be, input logic [4:0] rd, input logic [31:0] exp_d);
        push_exp(1'b1, rd, exp_d, 1'b0, 1'b1);
        mem_bus.mem_req_rdy = (stall == 0);
        issue(2'd1, size, uns, addr, 32'h0, rd, 1'b1);
        if (stall > 0) begin
            mem_bus.mem_rsp_vld  = 1'b1;
            mem_bus.mem_rsp_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        check_req(tag, 1'b0, addr, be);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (i == stall - 1) begin
                mem_bus.mem_req_rdy = 1'b1;
                mem_bus.mem_rsp_vld = 1'b0;
            end
            @(negedge clk);
            check_value({tag, "_req_held"}, 64'(mem_bus.mem_req_vld), 64'd1);
        end
        @(posedge clk); #1;
        mem_bus.mem_req_rdy = 1'b0;
        @(negedge clk);
        check_value({tag, "_rsp_wait_m_rdy"}, 64'(m_rdy), 64'd0);
        check_value({tag, "_rsp_wait_wb"}, 64'(wb_vld), 64'd0);
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld  = 1'b1;
        mem_bus.mem_rsp_data = rsp;
        @(negedge clk);
        check_value({tag, "_rsp_m_rdy"}, 64'(m_rdy), 64'd1);
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] st, input int stall, input logic [3:0] be,
                            input logic [31:0] wdata);
        push_exp(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
        mem_bus.mem_req_rdy = 1'b0;
        issue(2'd2, size, 1'b0, addr, st, 5'd3, 1'b1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_req(tag, 1'b1, addr, be);
            check_value({tag, "_wdata"}, 64'(mem_bus.mem_req_wdata), 64'(wdata));
            @(posedge clk); #1;
        end
        mem_bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        check_value({tag, "_acc_wdata"}, 64'(mem_bus.mem_req_wdata), 64'(wdata));
        check_value({tag, "_acc_wb"}, 64'(wb_vld), 64'd1);
        check_value({tag, "_acc_m_rdy"}, 64'(m_rdy), 64'd0);
        @(posedge clk); #1;
        mem_bus.mem_req_rdy = 1'b0;
        @(negedge clk);
        check_value({tag, "_done_m_rdy"}, 64'(m_rdy), 64'd1);
        check_value({tag, "_done_req"}, 64'(mem_bus.mem_req_vld), 64'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic [1:0] op, input logic [1:0] size,
                                 input logic [31:0] addr);
        push_exp(1'b0, 5'd4, 32'h0, 1'b1, 1'b0);
        mem_bus.mem_req_rdy = 1'b1;
        issue(op, size, 1'b0, addr, 32'h0, 5'd4, 1'b1);
        @(negedge clk);
        check_value({tag, "_no_req"}, 64'(mem_bus.mem_req_vld), 64'd0);
        check_value({tag, "_m_rdy"}, 64'(m_rdy), 64'd1);
        @(posedge clk); #1;
        mem_bus.mem_req_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; x_vld = 1'b0; exe_data_in = '0; st_data_in = '0;
        mem_op_in = '0; mem_size_in = '0; mem_uns_in = 1'b0; rd_addr_in = '0; rd_wen_in = 1'b0;
        mem_bus.mem_req_rdy = 1'b0; mem_bus.mem_rsp_vld = 1'b0; mem_bus.mem_rsp_data = '0;

        repeat (2) @(negedge clk);
        check_value("rst_m_rdy", 64'(m_rdy), 64'd1);
        check_value("rst_wb_vld", 64'(wb_vld), 64'd0);
        check_value("rst_req_vld", 64'(mem_bus.mem_req_vld), 64'd0);
        check_value("rst_data_out", 64'(data_out), 64'd0);
        check_value("rst_mis", 64'(misalign_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory ops, back to back, including illegal op 3
        push_exp(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
        issue(2'd0, 2'd0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        push_exp(1'b0, 5'd9, 32'h0000_55AA, 1'b0, 1'b1);
        issue(2'd3, 2'd2, 1'b0, 32'h0000_55AA, 32'h0, 5'd9, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // Loads
        do_load("lb",  2'd0, 1'b0, 32'h0000_0103, 32'h80FF_FF11, 0, 4'b1000, 5'd7,  32'hFFFF_FF80);
        do_load("lhu", 2'd1, 1'b1, 32'h0000_0102, 32'h8001_0000, 2, 4'b1100, 5'd8,  32'h0000_8001);
        do_load("lh",  2'd1, 1'b0, 32'h0000_0100, 32'h0000_9234, 0, 4'b0011, 5'd10, 32'hFFFF_9234);
        do_load("lbu", 2'd0, 1'b1, 32'h0000_0102, 32'h00C3_0000, 1, 4'b0100, 5'd11, 32'h0000_00C3);
        do_load("lw",  2'd2, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 0, 4'b1111, 5'd12, 32'hCAFE_F00D);

        // Stores
        do_store("sb", 2'd0, 32'h0000_0101, 32'h0000_00AB, 3, 4'b0010, 32'hABAB_ABAB);
        do_store("sh", 2'd1, 32'h0000_0106, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw", 2'd2, 32'h0000_0108, 32'h1122_3344, 1, 4'b1111, 32'h1122_3344);

        // Misaligned accesses (doubleword is never legal on 32 bits)
        do_misaligned("lw_mis", 2'd1, 2'd2, 32'h0000_0102);
        do_misaligned("sh_mis", 2'd2, 2'd1, 32'h0000_0105);
        do_misaligned("ld_mis", 2'd1, 2'd3, 32'h0000_0100);

        // Reset while a load waits in RSP: no writeback, late response ignored
        mem_bus.mem_req_rdy = 1'b1;
        issue(2'd1, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 5'd6, 1'b1);
        @(posedge clk); #1;
        mem_bus.mem_req_rdy = 1'b0;
        check_value("abort_pre_m_rdy", 64'(m_rdy), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_value("abort_m_rdy", 64'(m_rdy), 64'd1);
        check_value("abort_wb_vld", 64'(wb_vld), 64'd0);
        check_value("abort_req_vld", 64'(mem_bus.mem_req_vld), 64'd0);
        mem_bus.mem_rsp_vld  = 1'b1;
        mem_bus.mem_rsp_data = 32'h1357_9BDF;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_value("late_rsp_wb", 64'(wb_vld), 64'd0);
        end
        mem_bus.mem_rsp_vld = 1'b0;
        repeat (2) @(negedge clk);

        check_value("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
